// File: rtl/dht11_frame_ctrl_pkg.sv
// Shared types and constants for the DHT11 poll/frame controller: state encoding,
// error codes, frame geometry, default command/header bytes and the checksum helper.
package dht11_frame_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SEND  = 2'd1,
      ST_RECV  = 2'd2,
      ST_CHECK = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      ERR_NONE = 2'b00,
      ERR_HDR  = 2'b01,
      ERR_CHK  = 2'b10,
      ERR_TMO  = 2'b11
   } err_t;

   localparam int unsigned FRAME_LEN = 6;
   localparam int unsigned IDX_W     = 3;
   localparam int unsigned BYTE_W    = 8;
   localparam int unsigned SUM_W     = 10;

   localparam logic [BYTE_W-1:0] DEF_CMD_BYTE = 8'h55;
   localparam logic [BYTE_W-1:0] DEF_HDR_BYTE = 8'hAA;

   typedef struct packed {
      logic [BYTE_W-1:0] hum_int;
      logic [BYTE_W-1:0] hum_dec;
      logic [BYTE_W-1:0] temp_int;
      logic [BYTE_W-1:0] temp_dec;
   } reading_t;

   // Wide sum of the four payload bytes; the caller compares only the low byte.
   function automatic logic [BYTE_W-1:0] frame_sum(input reading_t r);
      logic [SUM_W-1:0] s;
      s = SUM_W'(r.hum_int) + SUM_W'(r.hum_dec) + SUM_W'(r.temp_int) + SUM_W'(r.temp_dec);
      return s[BYTE_W-1:0];
   endfunction

endpackage

// File: rtl/dht11_frame_ctrl_if.sv
// Bus bundle between the frame controller (master) and the UART / storage side (slave).
// The statistics counters exist only when DHT_FRAME_STATS_EN is defined.
interface dht11_frame_ctrl_if;
   import dht11_frame_ctrl_pkg::*;

   logic              poll_en;
   logic              tx_busy;
   logic              tx_start;
   logic [BYTE_W-1:0] tx_data;
   logic [BYTE_W-1:0] rx_data;
   logic              rx_done;
   logic [BYTE_W-1:0] hum_int;
   logic [BYTE_W-1:0] hum_dec;
   logic [BYTE_W-1:0] temp_int;
   logic [BYTE_W-1:0] temp_dec;
   logic              frame_valid;
   logic              frame_err;
   err_t              err_code;
   logic              busy;
`ifdef DHT_FRAME_STATS_EN
   logic [15:0]       ok_cnt;
   logic [15:0]       err_cnt;
`endif

   modport master (
      input  poll_en, tx_busy, rx_data, rx_done,
      output tx_start, tx_data, hum_int, hum_dec, temp_int, temp_dec,
             frame_valid, frame_err, err_code, busy
`ifdef DHT_FRAME_STATS_EN
      , output ok_cnt, err_cnt
`endif
   );

   modport slave (
      output poll_en, tx_busy, rx_data, rx_done,
      input  tx_start, tx_data, hum_int, hum_dec, temp_int, temp_dec,
             frame_valid, frame_err, err_code, busy
`ifdef DHT_FRAME_STATS_EN
      , input ok_cnt, err_cnt
`endif
   );

endinterface

// File: rtl/dht11_frame_ctrl_cycle_timer.sv
// Clear/enable cycle counter with a terminal-count flag at TERM-1; wraps to zero on terminal count.
module dht11_frame_ctrl_cycle_timer #(
   parameter int unsigned TERM = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tc_c
);
   localparam int unsigned CW = (TERM > 2) ? $clog2(TERM) : 1;

   logic [CW-1:0] cnt;

   assign tc_c = en && (cnt == CW'(TERM - 1));

   always_ff @(posedge clk) begin
      if (rst || clr || tc_c) cnt <= '0;
      else if (en)            cnt <= cnt + CW'(1);
   end

endmodule

// File: rtl/dht11_frame_ctrl.sv
// DHT11 poll scheduler and response frame assembler: sends CMD_BYTE every poll period,
// collects a 6-byte reply, validates header/checksum. Optional DHT_FRAME_STATS_EN adds ok/err counters.
module dht11_frame_ctrl
   import dht11_frame_ctrl_pkg::*;
#(
   parameter int unsigned       CLK_FREQ   = 1_000_000,
   parameter int unsigned       POLL_MS    = 2000,
   parameter int unsigned       TIMEOUT_MS = 100,
   parameter logic [BYTE_W-1:0] CMD_BYTE   = DEF_CMD_BYTE,
   parameter logic [BYTE_W-1:0] HDR_BYTE   = DEF_HDR_BYTE
) (
   input logic              clk,
   input logic              rst,
   dht11_frame_ctrl_if.master bus
);
   localparam int unsigned POLL_CYC = CLK_FREQ / 1000 * POLL_MS;
   localparam int unsigned TMO_CYC  = CLK_FREQ / 1000 * TIMEOUT_MS;

   state_t            state;
   logic [IDX_W-1:0]  idx;
   reading_t          frame_q;
   logic [BYTE_W-1:0] chk_q;
   reading_t          rd_q;
   logic              poll_tc_c;
   logic              tmo_tc_c;

   dht11_frame_ctrl_cycle_timer #(.TERM(POLL_CYC)) u_poll_tmr (
      .clk  (clk),
      .rst  (rst),
      .clr  ((state != ST_IDLE) || !bus.poll_en),
      .en   (bus.poll_en),
      .tc_c (poll_tc_c)
   );

   dht11_frame_ctrl_cycle_timer #(.TERM(TMO_CYC)) u_tmo_tmr (
      .clk  (clk),
      .rst  (rst),
      .clr  (state != ST_RECV),
      .en   (1'b1),
      .tc_c (tmo_tc_c)
   );

   assign bus.hum_int  = rd_q.hum_int;
   assign bus.hum_dec  = rd_q.hum_dec;
   assign bus.temp_int = rd_q.temp_int;
   assign bus.temp_dec = rd_q.temp_dec;

   // Transaction FSM; timeout takes priority over a coincident received byte.
   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= ST_IDLE;
         idx             <= '0;
         frame_q         <= '0;
         chk_q           <= '0;
         rd_q            <= '0;
         bus.tx_start    <= 1'b0;
         bus.tx_data     <= '0;
         bus.frame_valid <= 1'b0;
         bus.frame_err   <= 1'b0;
         bus.err_code    <= ERR_NONE;
         bus.busy        <= 1'b0;
      end else begin
         bus.tx_start    <= 1'b0;
         bus.frame_valid <= 1'b0;
         bus.frame_err   <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (poll_tc_c) begin
                  state    <= ST_SEND;
                  bus.busy <= 1'b1;
               end
            end
            ST_SEND: begin
               if (!bus.tx_busy) begin
                  bus.tx_start <= 1'b1;
                  bus.tx_data  <= CMD_BYTE;
                  idx          <= '0;
                  state        <= ST_RECV;
               end
            end
            ST_RECV: begin
               if (tmo_tc_c) begin
                  bus.frame_err <= 1'b1;
                  bus.err_code  <= ERR_TMO;
                  bus.busy      <= 1'b0;
                  state         <= ST_IDLE;
               end else if (bus.rx_done) begin
                  if (idx == '0 && bus.rx_data != HDR_BYTE) begin
                     bus.frame_err <= 1'b1;
                     bus.err_code  <= ERR_HDR;
                     bus.busy      <= 1'b0;
                     state         <= ST_IDLE;
                  end else begin
                     case (idx)
                        IDX_W'(1): frame_q.hum_int  <= bus.rx_data;
                        IDX_W'(2): frame_q.hum_dec  <= bus.rx_data;
                        IDX_W'(3): frame_q.temp_int <= bus.rx_data;
                        IDX_W'(4): frame_q.temp_dec <= bus.rx_data;
                        IDX_W'(5): chk_q            <= bus.rx_data;
                        default: ;
                     endcase
                     idx <= idx + IDX_W'(1);
                     if (idx == IDX_W'(FRAME_LEN - 1)) state <= ST_CHECK;
                  end
               end
            end
            ST_CHECK: begin
               if (frame_sum(frame_q) == chk_q) begin
                  rd_q            <= frame_q;
                  bus.frame_valid <= 1'b1;
                  bus.err_code    <= ERR_NONE;
               end else begin
                  bus.frame_err <= 1'b1;
                  bus.err_code  <= ERR_CHK;
               end
               bus.busy <= 1'b0;
               state    <= ST_IDLE;
            end
            default: begin
               bus.busy <= 1'b0;
               state    <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef DHT_FRAME_STATS_EN
   logic [15:0] ok_q;
   logic [15:0] bad_q;

   assign bus.ok_cnt  = ok_q;
   assign bus.err_cnt = bad_q;

   // Saturating outcome counters, bumped on the cycle each result pulse is visible.
   always_ff @(posedge clk) begin
      if (rst) begin
         ok_q  <= '0;
         bad_q <= '0;
      end else begin
         if (bus.frame_valid && ok_q != 16'hFFFF) ok_q  <= ok_q + 16'd1;
         if (bus.frame_err && bad_q != 16'hFFFF)  bad_q <= bad_q + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_dht11_frame_ctrl.sv
// Self-checking bench for dht11_frame_ctrl: directed scenarios plus randomized frames
// checked against a frame-level outcome model (header / length / checksum rules).
module tb_dht11_frame_ctrl;
   import dht11_frame_ctrl_pkg::*;

   localparam int unsigned POLL_CYC = 2000;
   localparam int unsigned TMO_CYC  = 1000;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   dht11_frame_ctrl_if bus ();

   dht11_frame_ctrl #(
      .CLK_FREQ   (1_000_000),
      .POLL_MS    (2),
      .TIMEOUT_MS (1),
      .CMD_BYTE   (8'h55),
      .HDR_BYTE   (8'hAA)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;
   int n_valid, n_err, n_both;
   logic [7:0] m_hi, m_hd, m_ti, m_td;
   logic [1:0] m_err;
   int m_ok, m_bad;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // One clock; samples 1 ns after the edge and tallies result pulses.
   task automatic tick();
      @(posedge clk);
      #1;
      if (bus.frame_valid) n_valid++;
      if (bus.frame_err) n_err++;
      if (bus.frame_valid && bus.frame_err) n_both++;
   endtask

   task automatic wait_start(input string tag);
      int n = 0;
      while (bus.tx_start !== 1'b1 && n < 3 * POLL_CYC) begin
         tick();
         n++;
      end
      chk({tag, "_tx_start"}, 16'(bus.tx_start), 16'h1);
      chk({tag, "_tx_data"}, 16'(bus.tx_data), 16'h55);
   endtask

   task automatic send_byte(input logic [7:0] b);
      bus.rx_data = b;
      bus.rx_done = 1'b1;
      tick();
      bus.rx_done = 1'b0;
   endtask

   task automatic check_outputs(input string tag);
      chk({tag, "_err_code"}, 16'(bus.err_code), 16'(m_err));
      chk({tag, "_hum_int"}, 16'(bus.hum_int), 16'(m_hi));
      chk({tag, "_hum_dec"}, 16'(bus.hum_dec), 16'(m_hd));
      chk({tag, "_temp_int"}, 16'(bus.temp_int), 16'(m_ti));
      chk({tag, "_temp_dec"}, 16'(bus.temp_dec), 16'(m_td));
`ifdef DHT_FRAME_STATS_EN
      chk({tag, "_ok_cnt"}, bus.ok_cnt, 16'(m_ok));
      chk({tag, "_err_cnt"}, bus.err_cnt, 16'(m_bad));
`endif
   endtask

   // Feeds the first nbytes of f after tx_start, then checks outcome against the model.
   task automatic do_frame(input logic [7:0] f [6], input int nbytes, input string tag);
      logic       bad_hdr;
      logic [1:0] e_err;
      int         s;
      n_valid = 0; n_err = 0; n_both = 0;
      bad_hdr = (nbytes > 0) && (f[0] != 8'hAA);
      s = (int'(f[1]) + int'(f[2]) + int'(f[3]) + int'(f[4])) % 256;
      if (bad_hdr)               e_err = 2'b01;
      else if (nbytes < 6)       e_err = 2'b11;
      else if (s == int'(f[5]))  e_err = 2'b00;
      else                       e_err = 2'b10;
      for (int i = 0; i < nbytes; i++) begin
         repeat ($urandom_range(0, 3)) tick();
         send_byte(f[i]);
         if (bad_hdr) begin
            chk({tag, "_hdr_err_now"}, 16'(bus.frame_err), 16'h1);
            break;
         end
      end
      if (e_err == 2'b11) begin
         int n = 0;
         while (n_err == 0 && n < int'(TMO_CYC) + 10) begin
            tick();
            n++;
         end
      end
      repeat (3) tick();
      if (e_err == 2'b00) begin
         m_hi = f[1]; m_hd = f[2]; m_ti = f[3]; m_td = f[4];
         m_ok++;
      end else begin
         m_bad++;
      end
      m_err = e_err;
      chk({tag, "_n_valid"}, 16'(n_valid), (e_err == 2'b00) ? 16'h1 : 16'h0);
      chk({tag, "_n_err"}, 16'(n_err), (e_err == 2'b00) ? 16'h0 : 16'h1);
      chk({tag, "_both_high"}, 16'(n_both), 16'h0);
      chk({tag, "_busy_after"}, 16'(bus.busy), 16'h0);
      check_outputs(tag);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] fr [6];
      int         t;
      logic       seen;
      rst = 1'b1;
      bus.poll_en = 1'b1;
      bus.tx_busy = 1'b0;
      bus.rx_data = 8'h00;
      bus.rx_done = 1'b0;
      m_hi = 0; m_hd = 0; m_ti = 0; m_td = 0; m_err = 2'b00; m_ok = 0; m_bad = 0;
      repeat (3) tick();
      chk("rst_tx_start", 16'(bus.tx_start), 16'h0);
      chk("rst_tx_data", 16'(bus.tx_data), 16'h0);
      chk("rst_busy", 16'(bus.busy), 16'h0);
      chk("rst_valid", 16'(bus.frame_valid), 16'h0);
      chk("rst_err", 16'(bus.frame_err), 16'h0);
      check_outputs("rst");
      rst = 1'b0;

      // First poll: SEND entered after POLL_CYC edges, command issued on the next.
      repeat (POLL_CYC - 1) tick();
      chk("poll_busy_before", 16'(bus.busy), 16'h0);
      tick();
      chk("poll_busy_send", 16'(bus.busy), 16'h1);
      chk("poll_no_start_yet", 16'(bus.tx_start), 16'h0);
      tick();
      chk("poll_tx_start", 16'(bus.tx_start), 16'h1);
      chk("poll_tx_data", 16'(bus.tx_data), 16'h55);
      chk("poll_busy_recv", 16'(bus.busy), 16'h1);
      tick();
      chk("tx_start_pulse", 16'(bus.tx_start), 16'h0);

      // 3C+00+19+05 = 0x5A
      fr = '{8'hAA, 8'h3C, 8'h00, 8'h19, 8'h05, 8'h5A};
      do_frame(fr, 6, "good");

      fr = '{8'hAA, 8'h3C, 8'h00, 8'h19, 8'h05, 8'h5B};
      wait_start("badchk");
      bus.poll_en = 1'b0;
      do_frame(fr, 6, "badchk");
      bus.poll_en = 1'b1;

      fr = '{8'hAB, 8'h3C, 8'h00, 8'h19, 8'h05, 8'h5A};
      wait_start("badhdr");
      do_frame(fr, 1, "badhdr");

      fr = '{8'hAA, 8'h01, 8'h02, 8'h00, 8'h00, 8'h00};
      wait_start("short");
      do_frame(fr, 3, "short");
      n_valid = 0; n_err = 0;
      send_byte(8'h77);
      repeat (3) tick();
      chk("late_byte_valid", 16'(n_valid), 16'h0);
      chk("late_byte_err", 16'(n_err), 16'h0);
      chk("late_byte_busy", 16'(bus.busy), 16'h0);

      // Last byte lands on the timeout edge: timeout must win.
      wait_start("coinc");
      n_valid = 0; n_err = 0;
      t = 0;
      fr = '{8'hAA, 8'h10, 8'h20, 8'h30, 8'h40, 8'hA0};
      for (int i = 0; i < 5; i++) begin
         send_byte(fr[i]);
         t++;
      end
      while (t < int'(TMO_CYC) - 1) begin
         tick();
         t++;
      end
      chk("coinc_no_err_early", 16'(n_err), 16'h0);
      send_byte(fr[5]);
      chk("coinc_frame_err", 16'(bus.frame_err), 16'h1);
      chk("coinc_frame_valid", 16'(bus.frame_valid), 16'h0);
      chk("coinc_err_code", 16'(bus.err_code), 16'h3);
      repeat (3) tick();
      m_err = 2'b11;
      m_bad++;
      chk("coinc_n_valid", 16'(n_valid), 16'h0);
      check_outputs("coinc");

      // tx_busy stalls the command.
      bus.tx_busy = 1'b1;
      t = 0;
      while (bus.busy !== 1'b1 && t < 3 * int'(POLL_CYC)) begin
         tick();
         t++;
      end
      seen = 1'b0;
      repeat (50) begin
         tick();
         if (bus.tx_start) seen = 1'b1;
      end
      chk("txbusy_stall", 16'(seen), 16'h0);
      chk("txbusy_still_busy", 16'(bus.busy), 16'h1);
      bus.tx_busy = 1'b0;
      tick();
      chk("txbusy_release_start", 16'(bus.tx_start), 16'h1);
      fr = '{8'hAA, 8'h2D, 8'h01, 8'h12, 8'h09, 8'h49};
      do_frame(fr, 6, "after_stall");

      // Randomized frames.
      for (int r = 0; r < 8; r++) begin
         int kind;
         int nb;
         kind = int'($urandom_range(0, 9));
         for (int i = 1; i < 5; i++) fr[i] = 8'($urandom_range(0, 255));
         fr[0] = 8'hAA;
         fr[5] = 8'((int'(fr[1]) + int'(fr[2]) + int'(fr[3]) + int'(fr[4])) % 256);
         nb = 6;
         if (kind == 0) begin
            fr[0] = 8'($urandom_range(0, 255));
            if (fr[0] == 8'hAA) fr[0] = 8'h00;
            nb = 1;
         end else if (kind == 1) begin
            fr[5] = 8'((int'(fr[5]) + 1 + int'($urandom_range(0, 254))) % 256);
         end else if (kind == 2) begin
            nb = int'($urandom_range(1, 5));
         end
         wait_start("rand");
         do_frame(fr, nb, "rand");
      end

      // poll_en low holds off polling.
      bus.poll_en = 1'b0;
      seen = 1'b0;
      repeat (POLL_CYC + 500) begin
         tick();
         if (bus.tx_start || bus.busy) seen = 1'b1;
      end
      chk("poll_dis_idle", 16'(seen), 16'h0);
      bus.poll_en = 1'b1;

      // Reset mid-RECV clears everything on the next edge.
      wait_start("midrst");
      send_byte(8'hAA);
      send_byte(8'h11);
      rst = 1'b1;
      tick();
      m_hi = 0; m_hd = 0; m_ti = 0; m_td = 0; m_err = 2'b00; m_ok = 0; m_bad = 0;
      chk("midrst_tx_start", 16'(bus.tx_start), 16'h0);
      chk("midrst_tx_data", 16'(bus.tx_data), 16'h0);
      chk("midrst_busy", 16'(bus.busy), 16'h0);
      chk("midrst_valid", 16'(bus.frame_valid), 16'h0);
      chk("midrst_err", 16'(bus.frame_err), 16'h0);
      check_outputs("midrst");
      rst = 1'b0;
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
